// File: rtl/id_stage_if.sv
// Fetch/write-back inputs and decoded outputs of the RV32I decode stage.
// master drives fetch/WB side and consumes decode results; slave is the decode stage.
interface id_stage_if;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcp4_f;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [31:0] pc_d;
  logic [31:0] pcp4_d;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] imm_d;
  logic [2:0]  funct3_d;
  logic        reg_write_d;
  logic        mem_read_d;
  logic        mem_write_d;
  logic        branch_d;
  logic        jump_d;
  logic        jalr_d;
  logic        alu_a_src_d;
  logic        alu_b_src_d;
  logic [3:0]  alu_ctrl_d;
  logic [1:0]  result_src_d;
  logic        illegal_d;

  modport master (
    output stall_d, flush_d, instr_f, pc_f, pcp4_f, wb_en, wb_rd, wb_data,
    input  pc_d, pcp4_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, funct3_d,
           reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, jalr_d,
           alu_a_src_d, alu_b_src_d, alu_ctrl_d, result_src_d, illegal_d
  );

  modport slave (
    input  stall_d, flush_d, instr_f, pc_f, pcp4_f, wb_en, wb_rd, wb_data,
    output pc_d, pcp4_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, funct3_d,
           reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d, jalr_d,
           alu_a_src_d, alu_b_src_d, alu_ctrl_d, result_src_d, illegal_d
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register with stall/flush, instruction decoder and
// 32x32 register file with write-first bypass from write-back.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  id_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcp4_q;
  logic [31:0] rf [32];

  always_ff @(posedge clk) begin
    if (rst || bus.flush_d) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      pcp4_q  <= RESET_PC;
    end else if (!bus.stall_d) begin
      instr_q <= bus.instr_f;
      pc_q    <= bus.pc_f;
      pcp4_q  <= bus.pcp4_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  // Write-first: a same-cycle write-back to the source register is forwarded.
  function automatic logic [31:0] read_port(input logic [4:0] rs, input logic [31:0] stored,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
    if (rs == 5'd0)             return 32'd0;
    else if (we && wa == rs)    return wd;
    else                        return stored;
  endfunction

  always_comb begin
    bus.rd1_d = read_port(rs1, rf[rs1], bus.wb_en, bus.wb_rd, bus.wb_data);
    bus.rd2_d = read_port(rs2, rf[rs2], bus.wb_en, bus.wb_rd, bus.wb_data);
  end

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // SUB only exists for register-register ops; immediate shifts still honour SRAI.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic reg_op);
    case (f3)
      3'd0:    return (alt && reg_op) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    bus.reg_write_d  = 1'b0;
    bus.mem_read_d   = 1'b0;
    bus.mem_write_d  = 1'b0;
    bus.branch_d     = 1'b0;
    bus.jump_d       = 1'b0;
    bus.jalr_d       = 1'b0;
    bus.alu_a_src_d  = 1'b0;
    bus.alu_b_src_d  = 1'b0;
    bus.alu_ctrl_d   = ALU_ADD;
    bus.result_src_d = 2'b00;
    bus.imm_d        = 32'd0;
    bus.illegal_d    = 1'b0;
    case (opcode)
      OP_R: begin
        bus.reg_write_d = 1'b1;
        bus.alu_ctrl_d  = alu_op(funct3, instr_q[30], 1'b1);
      end
      OP_I: begin
        bus.reg_write_d = 1'b1;
        bus.alu_b_src_d = 1'b1;
        bus.alu_ctrl_d  = alu_op(funct3, instr_q[30], 1'b0);
        bus.imm_d       = imm_i;
      end
      OP_LOAD: begin
        bus.reg_write_d  = 1'b1;
        bus.mem_read_d   = 1'b1;
        bus.alu_b_src_d  = 1'b1;
        bus.result_src_d = 2'b01;
        bus.imm_d        = imm_i;
      end
      OP_STORE: begin
        bus.mem_write_d = 1'b1;
        bus.alu_b_src_d = 1'b1;
        bus.imm_d       = imm_s;
      end
      OP_BRANCH: begin
        bus.branch_d   = 1'b1;
        bus.alu_ctrl_d = ALU_SUB;
        bus.imm_d      = imm_b;
      end
      OP_JAL: begin
        bus.reg_write_d  = 1'b1;
        bus.jump_d       = 1'b1;
        bus.result_src_d = 2'b10;
        bus.imm_d        = imm_j;
      end
      OP_JALR: begin
        bus.reg_write_d  = 1'b1;
        bus.jalr_d       = 1'b1;
        bus.alu_b_src_d  = 1'b1;
        bus.result_src_d = 2'b10;
        bus.imm_d        = imm_i;
      end
      OP_LUI: begin
        bus.reg_write_d = 1'b1;
        bus.alu_b_src_d = 1'b1;
        bus.alu_ctrl_d  = ALU_PASS_B;
        bus.imm_d       = imm_u;
      end
      OP_AUIPC: begin
        bus.reg_write_d = 1'b1;
        bus.alu_a_src_d = 1'b1;
        bus.alu_b_src_d = 1'b1;
        bus.imm_d       = imm_u;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: bus.illegal_d = 1'b1;
    endcase
  end

  assign bus.pc_d     = pc_q;
  assign bus.pcp4_d   = pcp4_q;
  assign bus.rs1_d    = rs1;
  assign bus.rs2_d    = rs2;
  assign bus.rd_d     = instr_q[11:7];
  assign bus.funct3_d = funct3;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode table, directed pipeline/regfile sequences and
// randomized traffic against a behavioural model of the stage.
module tb_id_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // ctrl = {reg_write, mem_read, mem_write, branch, jump, jalr, a_src, b_src, illegal}
  typedef struct packed {
    logic [8:0]  ctrl;
    logic [3:0]  alu;
    logic [1:0]  res;
    logic [31:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    dec_t        dec;
  } vec_t;

  logic [31:0] m_instr, m_pc, m_pcp4;
  logic [31:0] m_rf [32];

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic reg_op);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f3 == 3'd0 && alt && reg_op) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd7;
    return tab[f3];
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return $signed(i) >>> 20;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    int v;
    v = ($signed(i) >>> 25) * 32;
    v += int'(i[11:7]);
    return v;
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    int v;
    v = i[31] ? -4096 : 0;
    v += 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
    return v;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    int v;
    v = i[31] ? -1048576 : 0;
    v += 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
    return v;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    d = '0;
    case (i[6:0])
      7'h33: begin d.ctrl = 9'b100000000; d.alu = alu_of(i[14:12], i[30], 1'b1); end
      7'h13: begin d.ctrl = 9'b100000010; d.alu = alu_of(i[14:12], i[30], 1'b0); d.imm = imm_i(i); end
      7'h03: begin d.ctrl = 9'b110000010; d.res = 2'd1; d.imm = imm_i(i); end
      7'h23: begin d.ctrl = 9'b001000010; d.imm = imm_s(i); end
      7'h63: begin d.ctrl = 9'b000100000; d.alu = 4'd1; d.imm = imm_b(i); end
      7'h6F: begin d.ctrl = 9'b100010000; d.res = 2'd2; d.imm = imm_j(i); end
      7'h67: begin d.ctrl = 9'b100001010; d.res = 2'd2; d.imm = imm_i(i); end
      7'h37: begin d.ctrl = 9'b100000010; d.alu = 4'd10; d.imm = i & 32'hFFFF_F000; end
      7'h17: begin d.ctrl = 9'b100000110; d.imm = i & 32'hFFFF_F000; end
      7'h0F, 7'h73: ;
      default: d.ctrl = 9'b000000001;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == rs) return bus.wb_data;
    return m_rf[rs];
  endfunction

  function automatic dec_t act_dec();
    return {bus.reg_write_d, bus.mem_read_d, bus.mem_write_d, bus.branch_d, bus.jump_d,
            bus.jalr_d, bus.alu_a_src_d, bus.alu_b_src_d, bus.illegal_d,
            bus.alu_ctrl_d, bus.result_src_d, bus.imm_d};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_instr = NOP; m_pc = '0; m_pcp4 = '0;
      for (int k = 0; k < 32; k++) m_rf[k] = '0;
    end else begin
      if (bus.wb_en && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
      if (bus.flush_d) begin
        m_instr = NOP; m_pc = '0; m_pcp4 = '0;
      end else if (!bus.stall_d) begin
        m_instr = bus.instr_f; m_pc = bus.pc_f; m_pcp4 = bus.pcp4_f;
      end
    end
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic [192:0] act, exp;
    exp = {m_pc, m_pcp4, m_instr[19:15], m_instr[24:20], m_instr[11:7],
           rd_ref(m_instr[19:15]), rd_ref(m_instr[24:20]), m_instr[14:12], ref_decode(m_instr)};
    act = {bus.pc_d, bus.pcp4_d, bus.rs1_d, bus.rs2_d, bus.rd_d,
           bus.rd1_d, bus.rd2_d, bus.funct3_d, act_dec()};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    bus.instr_f = instr; bus.pc_f = pc; bus.pcp4_f = pc + 32'd4;
    tick();
  endtask

  vec_t tab [13];
  logic [6:0] ops [11];

  initial begin
    tab[0]  = '{32'h00500093, {9'b100000010, 4'd0,  2'd0, 32'h0000_0005}};
    tab[1]  = '{32'hFE000EE3, {9'b000100000, 4'd1,  2'd0, 32'hFFFF_FFFC}};
    tab[2]  = '{32'h008000EF, {9'b100010000, 4'd0,  2'd2, 32'h0000_0008}};
    tab[3]  = '{32'h0000007F, {9'b000000001, 4'd0,  2'd0, 32'h0000_0000}};
    tab[4]  = '{32'h123452B7, {9'b100000010, 4'd10, 2'd0, 32'h1234_5000}};
    tab[5]  = '{32'h0020A423, {9'b001000010, 4'd0,  2'd0, 32'h0000_0008}};
    tab[6]  = '{32'h402081B3, {9'b100000000, 4'd1,  2'd0, 32'h0000_0000}};
    tab[7]  = '{32'h4040D193, {9'b100000010, 4'd7,  2'd0, 32'h0000_0404}};
    tab[8]  = '{32'hFFC12283, {9'b110000010, 4'd0,  2'd1, 32'hFFFF_FFFC}};
    tab[9]  = '{32'h00001097, {9'b100000110, 4'd0,  2'd0, 32'h0000_1000}};
    tab[10] = '{32'h000280E7, {9'b100001010, 4'd0,  2'd2, 32'h0000_0000}};
    tab[11] = '{32'h00000073, {9'b000000000, 4'd0,  2'd0, 32'h0000_0000}};
    tab[12] = '{32'h003130B3, {9'b100000000, 4'd4,  2'd0, 32'h0000_0000}};
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

    rst = 1'b1;
    bus.stall_d = 0; bus.flush_d = 0; bus.instr_f = 32'hFFFF_FFFF; bus.pc_f = 32'h40;
    bus.pcp4_f = 32'h44; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    tick(); tick();
    rst = 1'b0;
    bus.stall_d = 1'b1;
    #1;
    check_all("reset_state");
    check_val("reset_ctrl", 32'(act_dec().ctrl & 9'b111111101), 32'(9'b100000000));
    check_val("reset_rd", 32'(bus.rd_d), 32'd0);
    bus.stall_d = 1'b0;

    load(32'h00500093, 32'd8);
    check_val("addi_pc", bus.pc_d, 32'd8);
    check_val("addi_rd", 32'(bus.rd_d), 32'd1);
    check_val("addi_imm", bus.imm_d, 32'd5);
    check_all("addi_full");

    for (int k = 0; k < 13; k++) begin
      load(tab[k].instr, 32'h100 + 32'(k) * 4);
      vectors++;
      if (act_dec() !== tab[k].dec) begin
        miscompares++;
        $display("FAIL table_%0d: got %h expected %h", k, act_dec(), tab[k].dec);
      end
      check_all($sformatf("table_full_%0d", k));
    end

    // bypass: add x4,x3,x3 in ID while x3 is written back
    load(32'h00318233, 32'h200);
    bus.wb_en = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    check_val("bypass_rd1", bus.rd1_d, 32'hDEAD_BEEF);
    check_val("bypass_rd2", bus.rd2_d, 32'hDEAD_BEEF);
    bus.stall_d = 1;
    tick();
    bus.wb_en = 0; #1;
    check_val("stored_rd1", bus.rd1_d, 32'hDEAD_BEEF);
    bus.stall_d = 0;

    // writes to x0 are dropped and never bypassed
    bus.wb_en = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'd7;
    load(32'h00000233, 32'h204);
    check_val("x0_bypass", bus.rd1_d, 32'd0);
    tick();
    bus.wb_en = 0; #1;
    check_val("x0_read", bus.rd1_d, 32'd0);

    // stall holds for three cycles, then flush beats stall
    load(32'h00500093, 32'h300);
    bus.stall_d = 1;
    for (int k = 0; k < 3; k++) begin
      load($urandom, $urandom);
      check_val($sformatf("stall_pc_%0d", k), bus.pc_d, 32'h300);
      check_val($sformatf("stall_imm_%0d", k), bus.imm_d, 32'd5);
    end
    bus.flush_d = 1;
    load(32'h008000EF, 32'h400);
    check_val("flush_pc", bus.pc_d, 32'd0);
    check_val("flush_rw", 32'(bus.reg_write_d), 32'd1);
    check_val("flush_jump", 32'(bus.jump_d), 32'd0);
    check_all("flush_full");
    bus.flush_d = 0; bus.stall_d = 0;

    // reset clears the register file and overrides a concurrent write
    bus.wb_en = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_0123;
    tick();
    rst = 1; bus.wb_rd = 5'd6; bus.wb_data = 32'h0000_0456;
    tick();
    rst = 0; bus.wb_en = 0;
    load(32'h00628233, 32'h500);
    check_val("rst_clear_x5", bus.rd1_d, 32'd0);
    check_val("rst_nowrite_x6", bus.rd2_d, 32'd0);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] instr, pc;
      instr = $urandom;
      if ($urandom_range(3) != 0) instr[6:0] = ops[$urandom_range(10)];
      pc = $urandom;
      bus.instr_f = instr; bus.pc_f = pc; bus.pcp4_f = pc + 32'd4;
      bus.stall_d = ($urandom_range(4) == 0);
      bus.flush_d = ($urandom_range(7) == 0);
      bus.wb_en = $urandom_range(1);
      bus.wb_rd = 5'($urandom_range(31));
      bus.wb_data = $urandom;
      #1;
      check_all($sformatf("rand_%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
